echo_multitap: RTL and testbench

- Parametrised successor to the fixed four-comb stereo echo.
- Sample-framed multi-tap echo with N channels, runtime-programmable tap delays, optional feedback, bypass and saturating mix.
- All delay lines share one time-multiplexed synchronous RAM, driven by a per-frame FSM.
- Sits between the codec input deserialiser and the output serialiser. One frame (all channels) is handled per codec sample strobe.

---
 rtl/echo_pkg.sv | 41 ++++
 rtl/echo_delay_ram.sv | 32 +++
 rtl/echo_multitap.sv | 226 ++++++++++++++++++++++
 tb/tb_echo_multitap.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
// Shared types and helpers for the multi-tap echo.
// Holds the frame FSM states, the saturator and the accumulator width rule.
package echo_pkg;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        RD,
        DRAIN,
        WR,
        DONE
    } state_e;

    // Wide enough for any sum the datapath hands to sat().
    localparam int SAT_MAXW = 128;

    // Sum of NUM_TAPS samples cannot overflow this width.
    function automatic int acc_width(input int width, input int taps);
        return width + $clog2(taps);
    endfunction

    // Clamp x to the signed range of a w-bit word.
    function automatic logic signed [SAT_MAXW-1:0] sat(
        input logic signed [SAT_MAXW-1:0] x,
        input int                         w
    );
        logic signed [SAT_MAXW-1:0] hi;
        logic signed [SAT_MAXW-1:0] lo;
        logic signed [SAT_MAXW-1:0] r;
        hi = $signed({1'b0, {(SAT_MAXW-1){1'b1}}} >> (SAT_MAXW - w));
        lo = ~hi;
        r  = x;
        if (x > hi) begin
            r = hi;
        end else if (x < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// Simple dual-port delay-line RAM: 1-cycle synchronous read, old data on
// same-address collision. Ports: clk, we/waddr/wdata, re/raddr, rdata.
module echo_delay_ram #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Non-blocking read and write on the same edge give read-old.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/echo_multitap.sv
// Frame-based N-channel multi-tap echo with feedback, bypass and saturation.
// Ports: CLOCK_50/resetn, frame handshake in_*, controls, out_valid/out_samples.
module echo_multitap
    import echo_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CHANNELS   = 2,
    parameter int NUM_TAPS   = 4,
    parameter int DEPTH_LOG2 = 13,
    parameter int WET_SHIFT  = 2
) (
    input  logic                           CLOCK_50,
    input  logic                           resetn,
    input  logic                           enable,
    input  logic                           fb_en,
    input  logic [4:0]                     fb_shift,
    input  logic [NUM_TAPS*DEPTH_LOG2-1:0] tap_delay,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHANNELS*WIDTH-1:0]      in_samples,
    output logic                           out_valid,
    output logic [CHANNELS*WIDTH-1:0]      out_samples
);

    localparam int ACC_W     = acc_width(WIDTH, NUM_TAPS);
    localparam int SUM_W     = ACC_W + 2;
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TAP_W     = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int ADDR_W    = CH_W + DEPTH_LOG2;
    localparam int RAM_DEPTH = CHANNELS << DEPTH_LOG2;

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(RAM_DEPTH - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [TAP_W-1:0]  TAP_LAST = TAP_W'(NUM_TAPS - 1);

    typedef logic [CHANNELS-1:0][WIDTH-1:0]      frame_t;
    typedef logic [NUM_TAPS-1:0][DEPTH_LOG2-1:0] delays_t;

    state_e                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [TAP_W-1:0]        tap_q, tap_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0]       clr_q, clr_d;
    frame_t                  samp_q, samp_d;
    frame_t                  stage_q, stage_d;
    frame_t                  out_q, out_d;
    delays_t                 dly_q, dly_d;
    logic                    en_q, en_d;
    logic                    fb_q, fb_d;
    logic [4:0]              fbs_q, fbs_d;
    logic                    out_valid_q, out_valid_d;

    logic                    ram_we;
    logic                    ram_re;
    logic [ADDR_W-1:0]       ram_waddr;
    logic [ADDR_W-1:0]       ram_raddr;
    logic [WIDTH-1:0]        ram_wdata;
    logic [WIDTH-1:0]        ram_rdata;

    logic [DEPTH_LOG2-1:0]   tap_dly;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic signed [WIDTH-1:0] dry;
    logic signed [WIDTH-1:0] rdata_s;
    logic signed [ACC_W-1:0] wet;
    logic signed [ACC_W-1:0] fbk;
    logic signed [SUM_W-1:0] mix_sum;
    logic signed [SUM_W-1:0] fb_sum;
    logic signed [WIDTH-1:0] mix_sat;
    logic signed [WIDTH-1:0] fb_sat;

    echo_delay_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (RAM_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (CLOCK_50),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= CLEAR;
            wr_ptr_q    <= '0;
            ch_q        <= '0;
            tap_q       <= '0;
            acc_q       <= '0;
            clr_q       <= '0;
            samp_q      <= '0;
            stage_q     <= '0;
            out_q       <= '0;
            dly_q       <= '0;
            en_q        <= 1'b0;
            fb_q        <= 1'b0;
            fbs_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            ch_q        <= ch_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            clr_q       <= clr_d;
            samp_q      <= samp_d;
            stage_q     <= stage_d;
            out_q       <= out_d;
            dly_q       <= dly_d;
            en_q        <= en_d;
            fb_q        <= fb_d;
            fbs_q       <= fbs_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR: if (clr_q == CLR_LAST) state_d = IDLE;
            IDLE:  if (in_valid) state_d = RD;
            RD:    if (tap_q == TAP_LAST) state_d = DRAIN;
            DRAIN: state_d = WR;
            WR:    state_d = (ch_q == CH_LAST) ? DONE : RD;
            DONE:  state_d = IDLE;
            default: state_d = CLEAR;
        endcase
    end

    // Tap address and mix arithmetic; sums are widened before clamping.
    always_comb begin
        tap_dly = dly_q[tap_q];
        if (tap_dly == '0) begin
            tap_dly = DEPTH_LOG2'(1);
        end
        rd_ptr  = wr_ptr_q - tap_dly;
        dry     = samp_q[ch_q];
        rdata_s = ram_rdata;
        wet     = acc_q >>> WET_SHIFT;
        fbk     = acc_q >>> fbs_q;
        mix_sum = SUM_W'(dry) + SUM_W'(wet);
        fb_sum  = SUM_W'(dry) + SUM_W'(fbk);
        mix_sat = WIDTH'(sat(SAT_MAXW'(mix_sum), WIDTH));
        fb_sat  = WIDTH'(sat(SAT_MAXW'(fb_sum), WIDTH));
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        ch_d        = ch_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        clr_d       = clr_q;
        samp_d      = samp_q;
        stage_d     = stage_q;
        out_d       = out_q;
        dly_d       = dly_q;
        en_d        = en_q;
        fb_d        = fb_q;
        fbs_d       = fbs_q;
        out_valid_d = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_waddr   = clr_q;
        ram_raddr   = {ch_q, rd_ptr};
        ram_wdata   = '0;
        unique case (state_q)
            CLEAR: begin
                ram_we = 1'b1;
                clr_d  = clr_q + 1'b1;
            end
            IDLE: begin
                if (in_valid) begin
                    samp_d = in_samples;
                    dly_d  = tap_delay;
                    en_d   = enable;
                    fb_d   = fb_en;
                    fbs_d  = fb_shift;
                    ch_d   = '0;
                    tap_d  = '0;
                    acc_d  = '0;
                end
            end
            RD: begin
                ram_re = 1'b1;
                // Data for tap t arrives one cycle after its read.
                if (tap_q != '0) begin
                    acc_d = acc_q + ACC_W'(rdata_s);
                end
                tap_d = (tap_q == TAP_LAST) ? '0 : tap_q + 1'b1;
            end
            DRAIN: begin
                acc_d = acc_q + ACC_W'(rdata_s);
            end
            WR: begin
                ram_we    = 1'b1;
                ram_waddr = {ch_q, wr_ptr_q};
                if (en_q) begin
                    stage_d[ch_q] = mix_sat;
                    ram_wdata     = fb_q ? fb_sat : dry;
                end else begin
                    // Bypass still records history for later re-enable.
                    stage_d[ch_q] = dry;
                    ram_wdata     = dry;
                end
                if (ch_q != CH_LAST) begin
                    ch_d  = ch_q + 1'b1;
                    acc_d = '0;
                end
            end
            DONE: begin
                out_valid_d = 1'b1;
                out_d       = stage_q;
                wr_ptr_d    = wr_ptr_q + 1'b1;
            end
            default: ;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign out_samples = out_q;

endmodule

// File: tb/tb_echo_multitap.sv
// Directed self-checking bench for echo_multitap.
// Table of frames with hand-computed outputs plus reset/back-pressure sequences.
module tb_echo_multitap;

    logic        CLOCK_50;
    logic        resetn;
    logic        enable;
    logic        fb_en;
    logic [4:0]  fb_shift;
    logic [51:0] tap_delay;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_samples;
    logic        out_valid;
    logic [63:0] out_samples;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        en;
        logic        fb;
        logic [4:0]  fbs;
        logic [51:0] dly;
        logic [31:0] in0;
        logic [31:0] in1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs[$];

    echo_multitap dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .enable      (enable),
        .fb_en       (fb_en),
        .fb_shift    (fb_shift),
        .tap_delay   (tap_delay),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_samples  (in_samples),
        .out_valid   (out_valid),
        .out_samples (out_samples)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [51:0] dl(input int a, input int b,
                                       input int c, input int d);
        return {13'(d), 13'(c), 13'(b), 13'(a)};
    endfunction

    task automatic add(input logic en, input logic fb, input logic [4:0] fbs,
                       input logic [51:0] dly,
                       input logic [31:0] in0, input logic [31:0] in1,
                       input logic [31:0] exp0, input logic [31:0] exp1);
        vec_t v;
        v.en = en; v.fb = fb; v.fbs = fbs; v.dly = dly;
        v.in0 = in0; v.in1 = in1; v.exp0 = exp0; v.exp1 = exp1;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_check(input string tag);
        int   n;
        logic ov_seen;
        n = 0;
        ov_seen = 1'b0;
        while (!in_ready && n < 20000) begin
            @(posedge CLOCK_50); #1;
            n++;
            if (out_valid) ov_seen = 1'b1;
        end
        check({tag, "_clear_len"}, 64'(n), 64'd16384);
        check({tag, "_clear_ovalid"}, {63'd0, ov_seen}, 64'd0);
        check({tag, "_clear_out"}, out_samples, 64'd0);
    endtask

    task automatic send_frame(input logic en, input logic fb,
                              input logic [4:0] fbs, input logic [51:0] dly,
                              input logic [31:0] s0, input logic [31:0] s1,
                              output int lat, output logic [63:0] outv);
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge CLOCK_50); #1;
            w++;
        end
        check("ready_wait", {63'd0, in_ready}, 64'd1);
        enable     = en;
        fb_en      = fb;
        fb_shift   = fbs;
        tap_delay  = dly;
        in_samples = {s1, s0};
        in_valid   = 1'b1;
        @(posedge CLOCK_50); #1;
        // Scramble inputs after accept; the block must use latched copies.
        in_valid   = 1'b0;
        in_samples = 64'hDEAD_BEEF_5A5A_A5A5;
        tap_delay  = '1;
        fb_shift   = 5'h1f;
        fb_en      = ~fb;
        enable     = ~en;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge CLOCK_50); #1;
            lat++;
        end
        outv = out_samples;
    endtask

    initial begin
        int          lat;
        int          pulses;
        logic [63:0] o;

        resetn     = 1'b1;
        enable     = 1'b0;
        fb_en      = 1'b0;
        fb_shift   = '0;
        tap_delay  = '0;
        in_valid   = 1'b0;
        in_samples = '0;

        // Impulse through taps {1,2,3,4}.
        add(1, 0, 0, dl(1, 2, 3, 4), 1000, 0, 1000, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 0, dl(1, 2, 3, 4), 0, 0, 250, 0);
        add(1, 0, 0, dl(1, 2, 3, 4), 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 0, dl(1, 2, 3, 4), 0, 0, 0, 0);
        // Feedback, all taps 8, fb_shift 3.
        for (int i = 0; i < 25; i++) begin
            logic [31:0] e;
            e = 0;
            if (i == 0 || i == 8) e = 1024;
            if (i == 16) e = 512;
            if (i == 24) e = 256;
            add(1, 1, 3, dl(8, 8, 8, 8), (i == 0) ? 1024 : 0, 0, e, 0);
        end
        for (int i = 0; i < 8; i++) add(0, 0, 0, dl(1, 1, 1, 1), 0, 0, 0, 0);
        // Saturation both rails.
        add(1, 0, 0, dl(1, 1, 1, 1), 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0);
        add(1, 0, 0, dl(1, 1, 1, 1), 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0);
        add(1, 0, 0, dl(1, 1, 1, 1), 32'h8000_0000, 0, 32'hFFFF_FFFF, 0);
        add(1, 0, 0, dl(1, 1, 1, 1), 32'h8000_0000, 0, 32'h8000_0000, 0);
        // Bypass, then delay 0 clamped to 1.
        add(0, 0, 0, dl(1, 1, 1, 1), 100, 0, 100, 0);
        add(0, 0, 0, dl(1, 1, 1, 1), 200, 0, 200, 0);
        add(1, 0, 0, dl(0, 0, 0, 0), 0, 0, 200, 0);

        #2 resetn = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out", out_samples, 64'd0);
        resetn = 1'b1;
        clear_check("init");

        foreach (vecs[i]) begin
            send_frame(vecs[i].en, vecs[i].fb, vecs[i].fbs, vecs[i].dly,
                       vecs[i].in0, vecs[i].in1, lat, o);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'd13);
            check($sformatf("vec%0d_ch0", i), {32'd0, o[31:0]},
                  {32'd0, vecs[i].exp0});
            check($sformatf("vec%0d_ch1", i), {32'd0, o[63:32]},
                  {32'd0, vecs[i].exp1});
        end

        // in_valid during RD must not be taken as a second frame.
        enable     = 1'b0;
        fb_en      = 1'b0;
        tap_delay  = dl(1, 1, 1, 1);
        in_samples = '0;
        in_valid   = 1'b1;
        @(posedge CLOCK_50); #1;
        in_valid = 1'b0;
        @(posedge CLOCK_50); #1;
        @(posedge CLOCK_50); #1;
        in_samples = {32'd0, 32'd777};
        in_valid   = 1'b1;
        @(posedge CLOCK_50); #1;
        check("bp_ready_in_rd", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge CLOCK_50); #1;
            if (out_valid) pulses++;
        end
        check("bp_frame_count", 64'(pulses), 64'd1);
        check("bp_out", out_samples, 64'd0);
        check("bp_idle_ready", {63'd0, in_ready}, 64'd1);

        // Reset during RD aborts the frame and re-runs CLEAR.
        enable     = 1'b1;
        in_samples = {32'd0, 32'd1234};
        in_valid   = 1'b1;
        @(posedge CLOCK_50); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        resetn = 1'b0;
        @(posedge CLOCK_50); #1;
        check("mid_rst_ready", {63'd0, in_ready}, 64'd0);
        check("mid_rst_ovalid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_out", out_samples, 64'd0);
        @(posedge CLOCK_50); #1;
        resetn = 1'b1;
        clear_check("mid");

        send_frame(0, 0, 0, dl(1, 1, 1, 1), 42, 7, lat, o);
        check("post_rst_lat", 64'(lat), 64'd13);
        check("post_rst_out", o, {32'd7, 32'd42});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
